// File: rtl/perm_drain_pkg.sv
// Shared types for the permutation core and its output drain: FSM states,
// 5x5 lane geometry, and the 64-bit lane word.
package perm_drain_pkg;

  localparam int LANES = 25;
  localparam int DIM   = 5;

  typedef logic [2:0]  coord_t;
  typedef logic [63:0] lane_t;

  localparam coord_t COORD_MAX = coord_t'(DIM - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/perm_drain_if.sv
// Drain-side bundle: start/busy/done control, lane memory read port, and the
// output lane stream.
interface perm_drain_if;

  logic                  start;
  logic                  busy;
  logic                  done;
  perm_drain_pkg::coord_t rx;
  perm_drain_pkg::coord_t ry;
  perm_drain_pkg::lane_t  rd;
  // Stream handshake: pushout is valid, stopout is the inverse of ready. A lane
  // moves on a posedge where pushout=1 and stopout=0; while stopout=1 the
  // producer holds pushout, firstout and dout unchanged.
  logic                  pushout;
  logic                  stopout;
  logic                  firstout;
  perm_drain_pkg::lane_t  dout;

  modport master (
    input  start, rd, stopout,
    output busy, done, rx, ry, pushout, firstout, dout
  );

  modport slave (
    output start, rd, stopout,
    input  busy, done, rx, ry, pushout, firstout, dout
  );

endinterface

// File: rtl/perm_drain_xy5_cnt.sv
// 5x5 lane pointer, x fastest; wraps from (4,4) back to (0,0).
module xy5_cnt
  import perm_drain_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   clr,
  input  logic   inc,
  output coord_t x,
  output coord_t y,
  output logic   last
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      x <= '0;
      y <= '0;
    end else if (inc) begin
      if (x == COORD_MAX) begin
        x <= '0;
        y <= (y == COORD_MAX) ? '0 : y + coord_t'(1);
      end else begin
        x <= x + coord_t'(1);
      end
    end
  end

  assign last = (x == COORD_MAX) && (y == COORD_MAX);

endmodule

// File: rtl/perm_drain.sv
// Streams the 25 lanes of a finished permutation state out of memory through a
// one-deep output register with a valid/stop handshake.
module perm_drain
  import perm_drain_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  perm_drain_if.master bus,
  output state_e      state_dbg
);

  state_e state_q, state_d;
  coord_t ptr_x, ptr_y;
  logic   ptr_last;
  logic   load, drain, cnt_clr;
  logic   pushout_q, firstout_q;
  lane_t  dout_q;

  xy5_cnt u_ptr (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (load),
    .x    (ptr_x),
    .y    (ptr_y),
    .last (ptr_last)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    drain   = 1'b0;
    cnt_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (bus.start) state_d = ST_SEND;
      end
      ST_SEND: begin
        // Refill whenever the register is empty or its lane leaves this edge.
        load = !pushout_q || !bus.stopout;
        if (load && ptr_last) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        drain = pushout_q && !bus.stopout;
        if (drain) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pushout_q  <= 1'b0;
      firstout_q <= 1'b0;
      dout_q     <= '0;
    end else if (load) begin
      pushout_q  <= 1'b1;
      firstout_q <= (ptr_x == '0) && (ptr_y == '0);
      dout_q     <= bus.rd;
    end else if (drain) begin
      pushout_q  <= 1'b0;
    end
  end

  assign bus.rx       = ptr_x;
  assign bus.ry       = ptr_y;
  assign bus.pushout  = pushout_q;
  assign bus.firstout = firstout_q;
  assign bus.dout     = dout_q;
  assign bus.busy     = (state_q == ST_SEND) || (state_q == ST_FLUSH);
  assign bus.done     = (state_q == ST_DONE);
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_perm_drain.sv
// Bench for perm_drain: cycle table for the opening of a drain, directed
// stall/reset/flush sequences, and randomized backpressure against a lane-order model.
module tb_perm_drain;
  import perm_drain_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  state_e state_dbg;
  perm_drain_if bus ();

  perm_drain dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  // Lane memory: lane(x,y) = 0x100*y + x, read combinationally.
  lane_t mem [5][5];
  assign bus.rd = (bus.rx < 3'd5 && bus.ry < 3'd5) ? mem[bus.ry][bus.rx] : '1;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: expected lane stream plus what the monitor saw.
  logic [63:0] exp_q[$];
  lane_t       got_q[$];
  bit          got_first_q[$];
  int          got_cyc_q[$];
  int          done_cyc_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.pushout && !bus.stopout) begin
        got_q.push_back(bus.dout);
        got_first_q.push_back(bus.firstout);
        got_cyc_q.push_back(cyc);
      end
      if (bus.done) done_cyc_q.push_back(cyc);
    end
  end

  // Reference: lane i of a drain is (x,y) = (i mod 5, i div 5).
  function automatic logic [63:0] exp_lane(input int i);
    return 64'((i / DIM) * 256 + (i % DIM));
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sb;
    exp_q.delete();
    got_q.delete();
    got_first_q.delete();
    got_cyc_q.delete();
    done_cyc_q.delete();
  endtask

  task automatic model_drain;
    for (int i = 0; i < LANES; i++) exp_q.push_back(exp_lane(i));
  endtask

  task automatic check_stream(input string name);
    int n;
    check({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_dout%0d", name, i), got_q[i], exp_q[i]);
      check($sformatf("%s_first%0d", name, i), 64'(got_first_q[i]), 64'((i % LANES) == 0));
    end
    check({name, "_done_count"}, 64'(done_cyc_q.size()), 64'd1);
  endtask

  task automatic check_idle(input string name);
    check({name, "_push"},  64'(bus.pushout),  64'd0);
    check({name, "_first"}, 64'(bus.firstout), 64'd0);
    check({name, "_dout"},  bus.dout,          64'd0);
    check({name, "_busy"},  64'(bus.busy),     64'd0);
    check({name, "_done"},  64'(bus.done),     64'd0);
    check({name, "_rx"},    64'(bus.rx),       64'd0);
    check({name, "_ry"},    64'(bus.ry),       64'd0);
    check({name, "_state"}, 64'(state_dbg),    64'(ST_IDLE));
  endtask

  task automatic start_pulse;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_done_seen"}, 64'(ok), 64'd1);
  endtask

  typedef struct {
    logic  start;
    logic  stop;
    logic  busy;
    logic  push;
    logic  first;
    int    ptr;
    lane_t dout;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, stalls;
    bit saw_103;

    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        mem[y][x] = 64'(256 * y + x);

    rst = 1'b1;
    bus.start = 1'b0;
    bus.stopout = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_idle("reset");

    // Cycle table: start, stall on lane (0,0), ignored start, two-cycle stall.
    vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 64'h000};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1, 64'h000};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1, 64'h000};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2, 64'h001};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3, 64'h002};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4, 64'h003};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4, 64'h003};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4, 64'h003};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5, 64'h004};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6, 64'h100};
    for (int i = 0; i < 10; i++) begin
      bus.start   = vecs[i].start;
      bus.stopout = vecs[i].stop;
      tick();
      check($sformatf("tab%0d_busy", i),  64'(bus.busy),     64'(vecs[i].busy));
      check($sformatf("tab%0d_push", i),  64'(bus.pushout),  64'(vecs[i].push));
      check($sformatf("tab%0d_first", i), 64'(bus.firstout), 64'(vecs[i].first));
      check($sformatf("tab%0d_dout", i),  bus.dout,          vecs[i].dout);
      check($sformatf("tab%0d_done", i),  64'(bus.done),     64'd0);
      check($sformatf("tab%0d_rx", i),    64'(bus.rx),       64'(vecs[i].ptr % 5));
      check($sformatf("tab%0d_ry", i),    64'(bus.ry),       64'(vecs[i].ptr / 5));
    end
    bus.start = 1'b0;
    bus.stopout = 1'b0;

    // Reset mid-drain returns everything to the idle values.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("midreset");

    // Free-running drain: latency, back-to-back lanes, done one cycle later.
    clear_sb();
    model_drain();
    start_pulse();
    t0 = cyc;
    wait_done("free", 100);
    tick();
    tick();
    check_stream("free");
    if (got_cyc_q.size() == LANES && done_cyc_q.size() == 1) begin
      check("free_first_cyc", 64'(got_cyc_q[0]), 64'(t0 + 1));
      check("free_span", 64'(got_cyc_q[LANES-1] - got_cyc_q[0]), 64'(LANES - 1));
      check("free_done_cyc", 64'(done_cyc_q[0]), 64'(got_cyc_q[LANES-1] + 1));
    end else begin
      check("free_timing_samples", 64'(got_cyc_q.size()), 64'(LANES));
    end

    // Three-cycle stall while lane (2,1) is presented.
    clear_sb();
    model_drain();
    start_pulse();
    stalls = 0;
    saw_103 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.pushout && bus.dout == 64'h102 && stalls < 3) begin
        bus.stopout = 1'b1;
        stalls++;
      end else begin
        bus.stopout = 1'b0;
      end
      tick();
      if (bus.stopout) check($sformatf("stall_hold%0d", stalls), bus.dout, 64'h102);
      else if (stalls == 3 && !saw_103) begin
        check("stall_next", bus.dout, 64'h103);
        saw_103 = 1'b1;
      end
      if (bus.done) break;
    end
    bus.stopout = 1'b0;
    check("stall_count", 64'(stalls), 64'd3);
    tick();
    tick();
    check_stream("stall");

    // stopout toggled every cycle.
    clear_sb();
    model_drain();
    bus.stopout = 1'($urandom_range(0, 1));
    start_pulse();
    for (int i = 0; i < 200; i++) begin
      bus.stopout = ~bus.stopout;
      tick();
      if (bus.done) break;
    end
    bus.stopout = 1'b0;
    check("toggle_done_seen", 64'(bus.done), 64'd1);
    tick();
    tick();
    check_stream("toggle");

    // Reset right after the 10th transfer abandons the drain.
    clear_sb();
    start_pulse();
    for (int i = 0; i < 100 && got_q.size() < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst10_push", 64'(bus.pushout), 64'd0);
    check("rst10_busy", 64'(bus.busy), 64'd0);
    repeat (40) tick();
    check("rst10_no_done", 64'(done_cyc_q.size()), 64'd0);
    check("rst10_xfers", 64'(got_q.size()), 64'd10);
    clear_sb();
    model_drain();
    start_pulse();
    wait_done("restart", 100);
    tick();
    tick();
    check_stream("restart");

    // Hold the last lane under stopout: FSM parks in FLUSH.
    clear_sb();
    model_drain();
    start_pulse();
    for (int i = 0; i < 100; i++) begin
      if (bus.pushout && bus.dout == 64'h404) break;
      tick();
    end
    bus.stopout = 1'b1;
    repeat (4) tick();
    check("flush_state", 64'(state_dbg), 64'(ST_FLUSH));
    check("flush_push", 64'(bus.pushout), 64'd1);
    check("flush_dout", bus.dout, 64'h404);
    check("flush_no_done", 64'(bus.done), 64'd0);
    bus.stopout = 1'b0;
    tick();
    check("flush_done", 64'(bus.done), 64'd1);
    check("flush_push_clr", 64'(bus.pushout), 64'd0);
    tick();
    check("flush_done_once", 64'(bus.done), 64'd0);
    check("flush_idle", 64'(bus.busy), 64'd0);
    tick();
    check_stream("flush");

    // Random backpressure with stray starts during the drain and at done.
    for (int r = 0; r < 3; r++) begin
      clear_sb();
      model_drain();
      start_pulse();
      for (int i = 0; i < 400; i++) begin
        bus.stopout = ($urandom_range(0, 2) == 0);
        bus.start   = ($urandom_range(0, 7) == 0);
        tick();
        if (bus.done) break;
      end
      bus.stopout = 1'b0;
      check($sformatf("rnd%0d_done_seen", r), 64'(bus.done), 64'd1);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (3) tick();
      check($sformatf("rnd%0d_idle", r), 64'(bus.busy), 64'd0);
      check($sformatf("rnd%0d_state", r), 64'(state_dbg), 64'(ST_IDLE));
      check_stream($sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
